// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP-style control unit.
//   - opcode constants for the supported instructions
//   - bit positions inside the 12-bit control word
//   - the fetch and execute control words driven onto con
//   - sequencer run/halt state type
package sap_pkg;

  localparam int CON_W = 12;
  localparam int T_W   = 6;

  // Opcodes (IR upper nibble)
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word bit positions; names starting with N are active-low
  localparam int CON_CP  = 11;
  localparam int CON_EP  = 10;
  localparam int CON_NLM = 9;
  localparam int CON_NCE = 8;
  localparam int CON_NLI = 7;
  localparam int CON_NEI = 6;
  localparam int CON_NLA = 5;
  localparam int CON_EA  = 4;
  localparam int CON_SU  = 3;
  localparam int CON_EU  = 2;
  localparam int CON_NLB = 1;
  localparam int CON_NLO = 0;

  // All strobes inactive
  localparam logic [CON_W-1:0] CON_IDLE    = 12'h3E3;
  // Fetch
  localparam logic [CON_W-1:0] CON_FETCH1  = 12'h5E3;  // Ep, nLm
  localparam logic [CON_W-1:0] CON_FETCH2  = 12'hBE3;  // Cp
  localparam logic [CON_W-1:0] CON_FETCH3  = 12'h263;  // nCE, nLi
  // Execute
  localparam logic [CON_W-1:0] CON_ADDR_IR = 12'h1A3;  // nEi, nLm
  localparam logic [CON_W-1:0] CON_RAM_A   = 12'h2C3;  // nCE, nLa
  localparam logic [CON_W-1:0] CON_RAM_B   = 12'h2E1;  // nCE, nLb
  localparam logic [CON_W-1:0] CON_ALU_ADD = 12'h3C7;  // Eu, nLa
  localparam logic [CON_W-1:0] CON_ALU_SUB = 12'h3CF;  // Su, Eu, nLa
  localparam logic [CON_W-1:0] CON_A_OUT   = 12'h3F2;  // Ea, nLo

  typedef enum logic {
    SEQ_RUN  = 1'b0,
    SEQ_HALT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/ring_counter.sv
// ring_counter: one-hot T1..T6 T-state counter.
//   clk      - system clock
//   clear    - synchronous active-high reset to T1
//   step_en  - advance enable; state holds when low
//   restart  - on a stepping edge, return to T1 instead of rotating
//   t_state  - one-hot T-state, bit0 = T1
module ring_counter
  import sap_pkg::*;
(
  input  logic           clk,
  input  logic           clear,
  input  logic           step_en,
  input  logic           restart,
  output logic [T_W-1:0] t_state
);

  logic [T_W-1:0] ring_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      ring_reg <= 6'b000001;
    end else if (step_en) begin
      if (restart) begin
        ring_reg <= 6'b000001;
      end else begin
        ring_reg <= {ring_reg[T_W-2:0], ring_reg[T_W-1]};
      end
    end
  end

  assign t_state = ring_reg;

endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer: T-state sequencer and control-word decoder.
//   clk        - system clock
//   clear      - synchronous active-high reset (to T1, not halted)
//   step_en    - advance enable for single-step operation
//   opcode     - IR upper nibble, valid T4..T6
//   con        - 12-bit control word (see sap_pkg for bit layout)
//   t_state    - one-hot T-state, zero while halted
//   instr_done - high in the final T-state of the current instruction
//   halted     - high while halted
// Parameter SKIP_NOP_STATES = 1 ends each instruction at its last active
// T-state instead of idling through T6.
module controller_sequencer
  import sap_pkg::*;
#(
  parameter bit SKIP_NOP_STATES = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             step_en,
  input  logic [3:0]       opcode,
  output logic [CON_W-1:0] con,
  output logic [T_W-1:0]   t_state,
  output logic             instr_done,
  output logic             halted
);

  seq_state_t     state_reg;
  logic [T_W-1:0] ring;
  logic           running;
  logic           is_nop;
  logic           restart;

  assign running = (state_reg == SEQ_RUN);
  assign is_nop  = !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT});

  // In the full-length mode T6 wraps to T1 by rotation, so an explicit
  // restart is only needed for shortened instructions.
  assign restart = SKIP_NOP_STATES && instr_done;

  ring_counter u_ring (
    .clk     (clk),
    .clear   (clear),
    .step_en (step_en && running),
    .restart (restart),
    .t_state (ring)
  );

  // Run/halt: HLT in T4 parks the sequencer until the next clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg <= SEQ_RUN;
    end else if (step_en && running && ring[3] && opcode == OP_HLT) begin
      state_reg <= SEQ_HALT;
    end
  end

  assign halted  = (state_reg == SEQ_HALT);
  assign t_state = running ? ring : '0;

  always_comb begin
    instr_done = 1'b0;
    if (running) begin
      if (SKIP_NOP_STATES) begin
        instr_done = (ring[2] && is_nop)
                  || (ring[3] && opcode == OP_OUT)
                  || (ring[4] && opcode == OP_LDA)
                  || (ring[5] && (opcode == OP_ADD || opcode == OP_SUB));
      end else begin
        instr_done = ring[5];
      end
    end
  end

  always_comb begin
    con = CON_IDLE;
    if (!clear && running) begin
      unique case (1'b1)
        ring[0]: con = CON_FETCH1;
        ring[1]: con = CON_FETCH2;
        ring[2]: con = CON_FETCH3;
        ring[3]: begin
          if (opcode inside {OP_LDA, OP_ADD, OP_SUB}) con = CON_ADDR_IR;
          else if (opcode == OP_OUT)                  con = CON_A_OUT;
        end
        ring[4]: begin
          if (opcode == OP_LDA)                       con = CON_RAM_A;
          else if (opcode inside {OP_ADD, OP_SUB})    con = CON_RAM_B;
        end
        ring[5]: begin
          if (opcode == OP_ADD)                       con = CON_ALU_ADD;
          else if (opcode == OP_SUB)                  con = CON_ALU_SUB;
        end
        default: con = CON_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer: directed checks of controller_sequencer in both
// the full-length (dut_a) and shortened (dut_b) sequencing modes. Both
// instances share clock and stimulus; each scenario checks one of them.
module tb_controller_sequencer;

  logic        clk;
  logic        clear;
  logic        step_en;
  logic [3:0]  opcode;
  logic [11:0] con_a, con_b;
  logic [5:0]  t_a, t_b;
  logic        done_a, done_b;
  logic        halt_a, halt_b;

  int n_checks = 0;
  int n_fail   = 0;

  controller_sequencer #(.SKIP_NOP_STATES(1'b0)) dut_a (
    .clk(clk), .clear(clear), .step_en(step_en), .opcode(opcode),
    .con(con_a), .t_state(t_a), .instr_done(done_a), .halted(halt_a)
  );

  controller_sequencer #(.SKIP_NOP_STATES(1'b1)) dut_b (
    .clk(clk), .clear(clear), .step_en(step_en), .opcode(opcode),
    .con(con_b), .t_state(t_b), .instr_done(done_b), .halted(halt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; step_en = 1'b1; opcode = 4'h0;
    tick();
    n_checks++; if (t_a !== 6'b000001) begin n_fail++; $display("FAIL reset_t: got %b expected %b", t_a, 6'b000001); end
    n_checks++; if (halt_a !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halt_a); end
    n_checks++; if (con_a !== 12'h3E3) begin n_fail++; $display("FAIL reset_con: got %h expected 3e3", con_a); end
    clear = 1'b0;
    #1;
    n_checks++; if (con_a !== 12'h5E3) begin n_fail++; $display("FAIL fetch_t1_con: got %h expected 5e3", con_a); end
    tick();
    n_checks++; if (t_a !== 6'b000010) begin n_fail++; $display("FAIL fetch_t2_t: got %b expected 000010", t_a); end
    n_checks++; if (con_a !== 12'hBE3) begin n_fail++; $display("FAIL fetch_t2_con: got %h expected be3", con_a); end
    tick();
    n_checks++; if (t_a !== 6'b000100) begin n_fail++; $display("FAIL fetch_t3_t: got %b expected 000100", t_a); end
    n_checks++; if (con_a !== 12'h263) begin n_fail++; $display("FAIL fetch_t3_con: got %h expected 263", con_a); end
    $display("test_reset: done at t=%0t", $time);
  endtask

  // Entered at T3; runs ADD then SUB and ends at T1.
  task automatic test_add_sub();
    opcode = 4'h1;
    tick();
    n_checks++; if (con_a !== 12'h1A3) begin n_fail++; $display("FAIL add_t4_con: got %h expected 1a3", con_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL add_t4_done: got %b expected 0", done_a); end
    tick();
    n_checks++; if (con_a !== 12'h2E1) begin n_fail++; $display("FAIL add_t5_con: got %h expected 2e1", con_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL add_t5_done: got %b expected 0", done_a); end
    tick();
    n_checks++; if (con_a !== 12'h3C7) begin n_fail++; $display("FAIL add_t6_con: got %h expected 3c7", con_a); end
    n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL add_t6_done: got %b expected 1", done_a); end
    n_checks++; if (t_a !== 6'b100000) begin n_fail++; $display("FAIL add_t6_t: got %b expected 100000", t_a); end
    tick();
    n_checks++; if (t_a !== 6'b000001) begin n_fail++; $display("FAIL add_wrap_t: got %b expected 000001", t_a); end
    tick();
    opcode = 4'h2;
    tick();
    tick();
    n_checks++; if (con_a !== 12'h1A3) begin n_fail++; $display("FAIL sub_t4_con: got %h expected 1a3", con_a); end
    tick();
    n_checks++; if (con_a !== 12'h2E1) begin n_fail++; $display("FAIL sub_t5_con: got %h expected 2e1", con_a); end
    tick();
    n_checks++; if (con_a !== 12'h3CF) begin n_fail++; $display("FAIL sub_t6_con: got %h expected 3cf", con_a); end
    n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL sub_t6_done: got %b expected 1", done_a); end
    tick();
    $display("test_add_sub: done at t=%0t", $time);
  endtask

  // Entered at T1; LDA paused in T5.
  task automatic test_step_gating();
    opcode = 4'h0;
    repeat (4) tick();
    n_checks++; if (t_a !== 6'b010000) begin n_fail++; $display("FAIL lda_t5_t: got %b expected 010000", t_a); end
    n_checks++; if (con_a !== 12'h2C3) begin n_fail++; $display("FAIL lda_t5_con: got %h expected 2c3", con_a); end
    step_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (t_a !== 6'b010000) begin n_fail++; $display("FAIL gate_hold_t[%0d]: got %b expected 010000", i, t_a); end
      n_checks++; if (con_a !== 12'h2C3) begin n_fail++; $display("FAIL gate_hold_con[%0d]: got %h expected 2c3", i, con_a); end
    end
    step_en = 1'b1;
    tick();
    n_checks++; if (t_a !== 6'b100000) begin n_fail++; $display("FAIL gate_resume_t: got %b expected 100000", t_a); end
    n_checks++; if (con_a !== 12'h3E3) begin n_fail++; $display("FAIL lda_t6_con: got %h expected 3e3", con_a); end
    tick();
    $display("test_step_gating: done at t=%0t", $time);
  endtask

  // Entered at T1.
  task automatic test_halt();
    opcode = 4'hF;
    repeat (3) tick();
    n_checks++; if (t_a !== 6'b001000) begin n_fail++; $display("FAIL hlt_t4_t: got %b expected 001000", t_a); end
    n_checks++; if (con_a !== 12'h3E3) begin n_fail++; $display("FAIL hlt_t4_con: got %h expected 3e3", con_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL hlt_t4_done: got %b expected 0", done_a); end
    tick();
    n_checks++; if (halt_a !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b expected 1", halt_a); end
    n_checks++; if (t_a !== 6'b000000) begin n_fail++; $display("FAIL halt_t: got %b expected 000000", t_a); end
    n_checks++; if (con_a !== 12'h3E3) begin n_fail++; $display("FAIL halt_con: got %h expected 3e3", con_a); end
    for (int i = 0; i < 10; i++) begin
      step_en = (i % 2 == 0);
      opcode  = 4'(i);
      tick();
      n_checks++; if (halt_a !== 1'b1 || t_a !== 6'b000000) begin n_fail++; $display("FAIL halt_sticky[%0d]: got halted=%b t=%b expected halted=1 t=000000", i, halt_a, t_a); end
    end
    step_en = 1'b1;
    clear   = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    n_checks++; if (halt_a !== 1'b0) begin n_fail++; $display("FAIL halt_clear_flag: got %b expected 0", halt_a); end
    n_checks++; if (t_a !== 6'b000001) begin n_fail++; $display("FAIL halt_clear_t: got %b expected 000001", t_a); end
    n_checks++; if (con_a !== 12'h5E3) begin n_fail++; $display("FAIL halt_clear_con: got %h expected 5e3", con_a); end
    $display("test_halt: done at t=%0t", $time);
  endtask

  // Entered at T1; clear during T5 of ADD.
  task automatic test_mid_reset();
    opcode = 4'h1;
    repeat (4) tick();
    n_checks++; if (con_a !== 12'h2E1) begin n_fail++; $display("FAIL mid_t5_con: got %h expected 2e1", con_a); end
    clear = 1'b1;
    tick();
    n_checks++; if (t_a !== 6'b000001) begin n_fail++; $display("FAIL mid_clear_t: got %b expected 000001", t_a); end
    n_checks++; if (con_a !== 12'h3E3) begin n_fail++; $display("FAIL mid_clear_con: got %h expected 3e3", con_a); end
    clear = 1'b0;
    #1;
    n_checks++; if (con_a !== 12'h5E3) begin n_fail++; $display("FAIL mid_t1_con: got %h expected 5e3", con_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL mid_t1_done: got %b expected 0", done_a); end
    tick();
    n_checks++; if (t_a !== 6'b000010) begin n_fail++; $display("FAIL mid_t2_t: got %b expected 000010", t_a); end
    $display("test_mid_reset: done at t=%0t", $time);
  endtask

  task automatic test_skip_nop();
    clear = 1'b1; step_en = 1'b1; opcode = 4'hE;
    tick();
    clear = 1'b0;
    repeat (3) tick();
    n_checks++; if (t_b !== 6'b001000) begin n_fail++; $display("FAIL skip_out_t: got %b expected 001000", t_b); end
    n_checks++; if (con_b !== 12'h3F2) begin n_fail++; $display("FAIL skip_out_con: got %h expected 3f2", con_b); end
    n_checks++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL skip_out_done: got %b expected 1", done_b); end
    tick();
    n_checks++; if (t_b !== 6'b000001) begin n_fail++; $display("FAIL skip_out_next: got %b expected 000001", t_b); end
    opcode = 4'h7;
    repeat (2) tick();
    n_checks++; if (t_b !== 6'b000100) begin n_fail++; $display("FAIL skip_nop_t: got %b expected 000100", t_b); end
    n_checks++; if (con_b !== 12'h263) begin n_fail++; $display("FAIL skip_nop_con: got %h expected 263", con_b); end
    n_checks++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL skip_nop_done: got %b expected 1", done_b); end
    tick();
    n_checks++; if (t_b !== 6'b000001) begin n_fail++; $display("FAIL skip_nop_next: got %b expected 000001", t_b); end
    opcode = 4'h0;
    repeat (3) tick();
    n_checks++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL skip_lda_t4_done: got %b expected 0", done_b); end
    tick();
    n_checks++; if (t_b !== 6'b010000) begin n_fail++; $display("FAIL skip_lda_t: got %b expected 010000", t_b); end
    n_checks++; if (con_b !== 12'h2C3) begin n_fail++; $display("FAIL skip_lda_con: got %h expected 2c3", con_b); end
    n_checks++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL skip_lda_done: got %b expected 1", done_b); end
    tick();
    n_checks++; if (t_b !== 6'b000001) begin n_fail++; $display("FAIL skip_lda_next: got %b expected 000001", t_b); end
    opcode = 4'h1;
    repeat (5) tick();
    n_checks++; if (t_b !== 6'b100000 || con_b !== 12'h3C7 || done_b !== 1'b1) begin n_fail++; $display("FAIL skip_add_t6: got t=%b con=%h done=%b expected t=100000 con=3c7 done=1", t_b, con_b, done_b); end
    tick();
    n_checks++; if (t_b !== 6'b000001) begin n_fail++; $display("FAIL skip_add_next: got %b expected 000001", t_b); end
    $display("test_skip_nop: done at t=%0t", $time);
  endtask

  initial begin
    clear = 1'b1; step_en = 1'b0; opcode = 4'h0;
    test_reset();
    test_add_sub();
    test_step_gating();
    test_halt();
    test_mid_reset();
    test_skip_nop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
